// File: rtl/decode_arith_stage.sv
// RV32 OP/OP-IMM arithmetic decoder with a valid/ready output stage.
// Output register plus one skid register; saturating illegal-instruction counter.
`timescale 1ns/1ps
module decode_arith_stage #(
    parameter bit ENABLE_M = 1'b1,
    parameter int TAG_W    = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_imm,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_kind,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [4:0] K_ADD  = 5'd1;
    localparam logic [4:0] K_SUB  = 5'd2;
    localparam logic [4:0] K_SLL  = 5'd3;
    localparam logic [4:0] K_SLT  = 5'd4;
    localparam logic [4:0] K_SLTU = 5'd5;
    localparam logic [4:0] K_XOR  = 5'd6;
    localparam logic [4:0] K_SRL  = 5'd7;
    localparam logic [4:0] K_SRA  = 5'd8;
    localparam logic [4:0] K_OR   = 5'd9;
    localparam logic [4:0] K_AND  = 5'd10;
    localparam logic [4:0] K_MUL  = 5'd11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    logic [4:0]       dec_kind;
    logic             dec_illegal;

    logic             out_v, skid_v;
    logic [4:0]       out_k, skid_k;
    logic             out_i, skid_i;
    logic [TAG_W-1:0] out_t, skid_t;
    logic [CNT_W-1:0] cnt;

    logic             acc, drain, load_out;

    // Kind 0 doubles as the illegal marker, so illegal is derived from it.
    always_comb begin
        dec_kind = 5'd0;
        if (in_is_imm) begin
            case (in_funct3)
                3'b000: dec_kind = K_ADD;
                3'b001: if (in_funct7 == F7_BASE) dec_kind = K_SLL;
                3'b010: dec_kind = K_SLT;
                3'b011: dec_kind = K_SLTU;
                3'b100: dec_kind = K_XOR;
                3'b101: begin
                    if (in_funct7 == F7_BASE)     dec_kind = K_SRL;
                    else if (in_funct7 == F7_ALT) dec_kind = K_SRA;
                end
                3'b110: dec_kind = K_OR;
                3'b111: dec_kind = K_AND;
            endcase
        end else if (in_funct7 == F7_BASE) begin
            case (in_funct3)
                3'b000: dec_kind = K_ADD;
                3'b001: dec_kind = K_SLL;
                3'b010: dec_kind = K_SLT;
                3'b011: dec_kind = K_SLTU;
                3'b100: dec_kind = K_XOR;
                3'b101: dec_kind = K_SRL;
                3'b110: dec_kind = K_OR;
                3'b111: dec_kind = K_AND;
            endcase
        end else if (in_funct7 == F7_ALT) begin
            if (in_funct3 == 3'b000)      dec_kind = K_SUB;
            else if (in_funct3 == 3'b101) dec_kind = K_SRA;
        end else if (ENABLE_M && in_funct7 == F7_M) begin
            dec_kind = K_MUL + {2'b00, in_funct3};
        end
        dec_illegal = (dec_kind == 5'd0);
    end

    // in_ready depends only on skid state, so nothing combinational reaches it from out_ready.
    assign in_ready = ~skid_v;
    assign acc      = in_valid & ~skid_v;
    assign drain    = out_v & out_ready;
    assign load_out = drain | ~out_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v  <= 1'b0;
            out_k  <= 5'd0;
            out_i  <= 1'b0;
            out_t  <= '0;
            skid_v <= 1'b0;
            skid_k <= 5'd0;
            skid_i <= 1'b0;
            skid_t <= '0;
            cnt    <= '0;
        end else begin
            if (drain && out_i && cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);
            if (flush) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
            end else if (load_out) begin
                if (skid_v) begin
                    out_v  <= 1'b1;
                    out_k  <= skid_k;
                    out_i  <= skid_i;
                    out_t  <= skid_t;
                    skid_v <= acc;
                    if (acc) begin
                        skid_k <= dec_kind;
                        skid_i <= dec_illegal;
                        skid_t <= in_tag;
                    end
                end else begin
                    out_v <= acc;
                    if (acc) begin
                        out_k <= dec_kind;
                        out_i <= dec_illegal;
                        out_t <= in_tag;
                    end
                end
            end else if (acc) begin
                skid_v <= 1'b1;
                skid_k <= dec_kind;
                skid_i <= dec_illegal;
                skid_t <= in_tag;
            end
        end
    end

    assign out_valid     = out_v;
    assign out_kind      = out_k;
    assign out_illegal   = out_i;
    assign out_tag       = out_t;
    assign illegal_count = cnt;

endmodule

// File: tb/tb_decode_arith_stage.sv
// Directed bench for decode_arith_stage: three instances (M enabled, M disabled,
// 2-bit counter) share one stimulus stream; expectations are hand-computed.
`timescale 1ns/1ps
module tb_decode_arith_stage;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_is_imm, out_ready;
    logic [2:0] in_funct3;
    logic [6:0] in_funct7;
    logic [7:0] in_tag;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [4:0]  a_out_kind;
    logic [7:0]  a_out_tag;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [4:0]  b_out_kind;
    logic [7:0]  b_out_tag;
    logic [15:0] b_cnt;
    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [4:0]  c_out_kind;
    logic [7:0]  c_out_tag;
    logic [1:0]  c_cnt;

    int checks = 0;
    int errors = 0;
    int main_cnt = 0;
    int m0_cnt = 0;

    decode_arith_stage #(.ENABLE_M(1'b1), .TAG_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_is_imm(in_is_imm), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_kind(a_out_kind),
        .out_illegal(a_out_illegal), .out_tag(a_out_tag), .illegal_count(a_cnt));

    decode_arith_stage #(.ENABLE_M(1'b0), .TAG_W(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_is_imm(in_is_imm), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_kind(b_out_kind),
        .out_illegal(b_out_illegal), .out_tag(b_out_tag), .illegal_count(b_cnt));

    decode_arith_stage #(.ENABLE_M(1'b1), .TAG_W(8), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_is_imm(in_is_imm), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_tag(in_tag),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_kind(c_out_kind),
        .out_illegal(c_out_illegal), .out_tag(c_out_tag), .illegal_count(c_cnt));

    always #5 clk = ~clk;

    // {is_imm, funct3, funct7, kind with M, kind without M}
    localparam logic [20:0] TBL [14] = '{
        {1'b0, 3'b000, 7'b0000000, 5'd1,  5'd1},
        {1'b0, 3'b000, 7'b0100000, 5'd2,  5'd2},
        {1'b0, 3'b101, 7'b0100000, 5'd8,  5'd8},
        {1'b0, 3'b110, 7'b0000001, 5'd17, 5'd0},
        {1'b1, 3'b000, 7'b0000001, 5'd1,  5'd1},
        {1'b1, 3'b001, 7'b0100000, 5'd0,  5'd0},
        {1'b0, 3'b010, 7'b0100000, 5'd0,  5'd0},
        {1'b0, 3'b001, 7'b0000001, 5'd12, 5'd0},
        {1'b1, 3'b101, 7'b0100000, 5'd8,  5'd8},
        {1'b1, 3'b010, 7'b1111111, 5'd4,  5'd4},
        {1'b0, 3'b111, 7'b0000000, 5'd10, 5'd10},
        {1'b0, 3'b011, 7'b0000001, 5'd14, 5'd0},
        {1'b0, 3'b100, 7'b0000010, 5'd0,  5'd0},
        {1'b1, 3'b101, 7'b0000000, 5'd7,  5'd7}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic imm, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [7:0] tag);
        in_valid  = v;
        in_is_imm = imm;
        in_funct3 = f3;
        in_funct7 = f7;
        in_tag    = tag;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        logic [20:0] e;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 7'b0, 8'h00);
        #1;
        chk("rst_in_ready", a_in_ready, 1);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_kind", a_out_kind, 0);
        chk("rst_out_illegal", a_out_illegal, 0);
        chk("rst_out_tag", a_out_tag, 0);
        chk("rst_count", a_cnt, 0);
        chk("rst_in_ready_after", a_in_ready, 1);

        // back-to-back stream with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            e = TBL[i];
            drive(1'b1, e[20], e[19:17], e[16:10], 8'(16 + i));
            tick();
            chk("str_valid", a_out_valid, 1);
            chk("str_kind_m", a_out_kind, e[9:5]);
            chk("str_ill_m", a_out_illegal, (e[9:5] == 5'd0));
            chk("str_tag", a_out_tag, 16 + i);
            chk("str_kind_nom", b_out_kind, e[4:0]);
            chk("str_ill_nom", b_out_illegal, (e[4:0] == 5'd0));
            chk("str_in_ready", a_in_ready, 1);
            if (e[9:5] == 5'd0) main_cnt++;
            if (e[4:0] == 5'd0) m0_cnt++;
        end
        drive(1'b0, 1'b0, 3'b000, 7'b0, 8'h00);
        tick();
        chk("str_drained", a_out_valid, 0);
        chk("str_cnt_m", a_cnt, main_cnt);
        chk("str_cnt_nom", b_cnt, m0_cnt);
        chk("str_cnt_sat", c_cnt, sat3(main_cnt));

        // backpressure: A, B accepted, C held upstream
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 7'b0000000, 8'hA1);
        tick();
        chk("bp_a_valid", a_out_valid, 1);
        chk("bp_a_ready", a_in_ready, 1);
        drive(1'b1, 1'b0, 3'b001, 7'b0000000, 8'hB2);
        tick();
        chk("bp_b_ready", a_in_ready, 0);
        chk("bp_b_hold_tag", a_out_tag, 8'hA1);
        drive(1'b1, 1'b0, 3'b100, 7'b0000000, 8'hC3);
        tick();
        chk("bp_c_ready", a_in_ready, 0);
        chk("bp_c_hold_tag", a_out_tag, 8'hA1);
        tick();
        chk("bp_hold_kind", a_out_kind, 1);
        chk("bp_hold_tag2", a_out_tag, 8'hA1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_out_valid", a_out_valid, 1);
        chk("bp_b_out_tag", a_out_tag, 8'hB2);
        chk("bp_b_out_kind", a_out_kind, 3);
        chk("bp_ready_back", a_in_ready, 1);
        tick();
        chk("bp_c_out_valid", a_out_valid, 1);
        chk("bp_c_out_tag", a_out_tag, 8'hC3);
        chk("bp_c_out_kind", a_out_kind, 6);
        drive(1'b0, 1'b0, 3'b000, 7'b0, 8'h00);
        tick();
        chk("bp_empty", a_out_valid, 0);

        // flush with both entries full and an input pending
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 7'b0100000, 8'hD1);
        tick();
        drive(1'b1, 1'b0, 3'b010, 7'b0100000, 8'hD2);
        tick();
        chk("fl_full", a_in_ready, 0);
        drive(1'b1, 1'b0, 3'b000, 7'b0000000, 8'hD3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 7'b0, 8'h00);
        chk("fl_out_valid", a_out_valid, 0);
        chk("fl_in_ready", a_in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("fl_nothing1", a_out_valid, 0);
        tick();
        chk("fl_nothing2", a_out_valid, 0);
        chk("fl_cnt", a_cnt, main_cnt);

        // input accepted in a flush cycle is discarded
        drive(1'b1, 1'b0, 3'b000, 7'b0000000, 8'hE0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 7'b0, 8'h00);
        chk("fl_in_drop", a_out_valid, 0);

        // output handshake during flush still counts
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 7'b0100000, 8'hE1);
        tick();
        drive(1'b0, 1'b0, 3'b000, 7'b0, 8'h00);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        main_cnt++;
        m0_cnt++;
        chk("flh_valid", a_out_valid, 0);
        chk("flh_cnt_m", a_cnt, main_cnt);
        chk("flh_cnt_nom", b_cnt, m0_cnt);
        chk("flh_cnt_sat", c_cnt, sat3(main_cnt));

        // 2-bit counter saturation from a fresh reset
        rst = 1'b1;
        #1;
        chk("sat_rst_cnt", c_cnt, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 3'b010, 7'b0100000, 8'(i));
            tick();
            chk("sat_cnt", c_cnt, sat3(i));
        end
        drive(1'b0, 1'b0, 3'b000, 7'b0, 8'h00);
        tick();
        chk("sat_cnt_final", c_cnt, 3);
        chk("sat_cnt_wide", a_cnt, 5);

        // reset in the middle of a stalled transfer
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 7'b0100000, 8'h09);
        tick();
        drive(1'b1, 1'b0, 3'b000, 7'b0000000, 8'h0A);
        tick();
        chk("mr_pre_valid", a_out_valid, 1);
        chk("mr_pre_ready", a_in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mr_out_valid", a_out_valid, 0);
        chk("mr_out_illegal", a_out_illegal, 0);
        chk("mr_out_tag", a_out_tag, 0);
        chk("mr_out_kind", a_out_kind, 0);
        chk("mr_in_ready", a_in_ready, 1);
        chk("mr_cnt", a_cnt, 0);
        chk("mr_cnt_sat", c_cnt, 0);
        drive(1'b0, 1'b0, 3'b000, 7'b0, 8'h00);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mr_after", a_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_arith_stage.md
# decode_arith_stage

Pipelined decoder for RV32 integer arithmetic instructions: classifies funct3/funct7 of OP (register-register) and OP-IMM instructions into an operation kind, with optional M-extension support. Sits between fetch/instruction-split and the execute stage, replacing the single-register reg-arith decoder with a valid/ready stage. A two-entry skid buffer provides full throughput under backpressure. Also adds strict illegal-encoding detection, a flush input and a saturating illegal-instruction counter.

## Interface
- ENABLE_M, 1: 1 decodes funct7=0000001 OP instructions as M-extension ops; 0 treats them as illegal.
- TAG_W, 8: width of the opaque sideband tag carried with each instruction.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept; equals "skid entry empty".
- in_is_imm  input  1  1 = OP-IMM, 0 = OP.
- in_funct3  input  3  instruction bits [14:12].
- in_funct7  input  7  instruction bits [31:25].
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  decoded entry available.
- out_ready  input  1  downstream accepts.
- out_kind  output  5  operation code (see Operation).
- out_illegal  output  1  encoding not legal; out_kind is 0 when set.
- out_tag  output  TAG_W  tag of the presented entry.
- illegal_count  output  CNT_W  illegal entries retired, saturating.

## Operation
- Kind codes: 0 invalid, 1 add, 2 sub, 3 sll, 4 slt, 5 sltu, 6 xor, 7 srl, 8 sra, 9 or, 10 and, 11 mul, 12 mulh, 13 mulhsu, 14 mulhu, 15 div, 16 divu, 17 rem, 18 remu.
- OP, funct7=0000000: funct3 000..111 map to add, sll, slt, sltu, xor, srl, or, and.
- OP, funct7=0100000: funct3 000 gives sub and 101 gives sra; all other funct3 values are illegal.
- OP, funct7=0000001, ENABLE_M=1: funct3 000..111 map to mul, mulh, mulhsu, mulhu, div, divu, rem, remu. With ENABLE_M=0 these encodings are illegal.
- OP, any other funct7: illegal.
- OP-IMM: funct3 000/010/011/100/110/111 give add/slt/sltu/xor/or/and, and funct7 is ignored (it is immediate bits). funct3 001 with funct7=0000000 gives sll; any other funct7 is illegal. funct3 101 with funct7 0000000 gives srl, 0100000 gives sra, anything else is illegal. M ops never apply to OP-IMM.
- Storage is an output register plus one skid register, each holding valid/kind/illegal/tag.
- Input handshake fires when in_valid & in_ready. Output handshake fires when out_valid & out_ready.
- An accepted entry goes to the output register when that register is empty or is being drained in the same cycle; otherwise it goes to the skid register.
- When the output drains and the skid register is full, the skid entry moves to the output register. If an input is also accepted that cycle, it fills the skid register.
- Order is strictly FIFO. No entry is ever dropped except by flush.
- illegal_count increments by 1 on each output handshake with out_illegal=1 and holds at 2^CNT_W-1. Flushed entries are not counted.
- Flush: next edge clears both valid bits. An input presented in the flush cycle is discarded. An output handshake in the flush cycle still counts toward illegal_count.

## Timing
- Reset values: out_valid=0, out_kind=0, out_illegal=0, out_tag=0, illegal_count=0, skid empty, so in_ready=1 while rst is high and after it deasserts. Reset mid-transfer discards all entries.
- Latency: an instruction accepted at edge N is on the outputs after edge N (visible in cycle N+1).
- Throughput: one instruction per cycle while out_ready=1.
- in_ready is registered state (skid empty) with no combinational path from out_ready. It drops to 0 the cycle after the skid register fills. It returns to 1 the cycle after the skid entry moves to the output register.
- While out_valid=1 and out_ready=0, out_kind/out_illegal/out_tag are held stable.
- Data outputs are don't-care when out_valid=0, except immediately after reset.

## Test plan
- Reset then stream OP {f3=000,f7=0000000},{000,0100000},{101,0100000} with out_ready=1 -> out_kind 1, 2, 8 on consecutive cycles, each one cycle after acceptance, out_illegal=0.
- ENABLE_M=1 vs 0: OP f7=0000001, f3=110 -> kind 17 vs illegal (kind 0, out_illegal=1). OP-IMM f7=0000001, f3=000 -> kind 1 in both configurations.
- OP-IMM f3=001 f7=0100000 and OP f3=010 f7=0100000 -> both illegal. After both retire, illegal_count=2.
- Backpressure: send 3 back-to-back with out_ready=0 -> first two accepted, in_ready=0 from the cycle after the second, third held upstream. Raise out_ready -> all three emerge in order with tags intact, no gaps.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing from those three ever appears, illegal_count unchanged.
- CNT_W=2: retire 5 illegal entries -> illegal_count reads 1, 2, 3, 3, 3. Assert rst mid-stream -> all outputs return to reset values immediately.
